// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, mouse command bytes
// and the odd-parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StData,
      StParity,
      StStop,
      StAck,
      StWaitIdle
   } ps2_tx_state;

   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
   localparam logic [7:0] PS2_ACK_BYTE   = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines, with
// falling-edge detect one cycle after the synchronized level.
module ps2_line_sync (
   input  logic Clk,
   input  logic Reset,
   input  logic ps2_clk_in,
   input  logic ps2_dat_in,
   output logic sync_clk,
   output logic sync_dat,
   output logic clk_fall,
   output logic dat_fall
);

   logic [1:0] clk_sync_q;
   logic [1:0] dat_sync_q;
   logic       clk_prev_q;
   logic       dat_prev_q;

   // Idle bus level is high, so reset to 1 to avoid a spurious fall.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
         dat_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
         clk_prev_q <= clk_sync_q[1];
         dat_prev_q <= dat_sync_q[1];
      end
   end

   assign sync_clk = clk_sync_q[1];
   assign sync_dat = dat_sync_q[1];
   assign clk_fall = clk_prev_q & ~clk_sync_q[1];
   assign dat_fall = dat_prev_q & ~dat_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clock out
// data/parity/stop on device clock falls, then check the device ack.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned REQ_CYCLES     = 100,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned PhaseMax =
      (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
   localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PhaseW-1:0]   InhibitLast = PhaseW'(INHIBIT_CYCLES - 1);
   localparam logic [PhaseW-1:0]   ReqLast     = PhaseW'(REQ_CYCLES - 1);
   localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

   logic sync_clk, sync_dat, clk_fall, dat_fall_unused;

   ps2_line_sync u_line_sync (
      .Clk        (Clk),
      .Reset      (Reset),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .sync_clk   (sync_clk),
      .sync_dat   (sync_dat),
      .clk_fall   (clk_fall),
      .dat_fall   (dat_fall_unused)
   );

   ps2_tx_state         state_q, state_d;
   logic [PhaseW-1:0]   phase_q, phase_d;
   logic [TimeoutW-1:0] tocnt_q, tocnt_d;
   logic [7:0]          shreg_q, shreg_d;
   logic [2:0]          bitcnt_q, bitcnt_d;
   logic                par_q, par_d;
   logic                ack_ok_q, ack_ok_d;
   logic                dat_oe_q, dat_oe_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                timed;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         phase_q  <= '0;
         tocnt_q  <= '0;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         par_q    <= 1'b0;
         ack_ok_q <= 1'b0;
         dat_oe_q <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         tocnt_q  <= tocnt_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         par_q    <= par_d;
         ack_ok_q <= ack_ok_d;
         dat_oe_q <= dat_oe_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      par_d    = par_q;
      ack_ok_d = ack_ok_q;
      dat_oe_d = dat_oe_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      tocnt_d  = (tocnt_q < TimeoutLast) ? tocnt_q + 1'b1 : tocnt_q;
      timed    = 1'b0;

      unique case (state_q)
         StIdle: begin
            tocnt_d = '0;
            phase_d = '0;
            // Completion cycle still reads as idle; a start there is dropped.
            if (tx_start && !done_q && !error_q) begin
               shreg_d = tx_data;
               par_d   = odd_parity(tx_data);
               state_d = StInhibit;
            end
         end
         StInhibit: begin
            if (phase_q == InhibitLast) begin
               phase_d  = '0;
               dat_oe_d = 1'b1;
               state_d  = StReq;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         StReq: begin
            if (phase_q == ReqLast) begin
               phase_d  = '0;
               bitcnt_d = '0;
               tocnt_d  = '0;
               state_d  = StData;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         StData: begin
            timed = 1'b1;
            if (clk_fall) begin
               dat_oe_d = ~shreg_q[0];
               shreg_d  = shreg_q >> 1;
               bitcnt_d = bitcnt_q + 1'b1;
               tocnt_d  = '0;
               if (bitcnt_q == 3'd7) state_d = StParity;
            end
         end
         StParity: begin
            timed = 1'b1;
            if (clk_fall) begin
               dat_oe_d = ~par_q;
               tocnt_d  = '0;
               state_d  = StStop;
            end
         end
         StStop: begin
            timed = 1'b1;
            if (clk_fall) begin
               dat_oe_d = 1'b0;
               tocnt_d  = '0;
               state_d  = StAck;
            end
         end
         StAck: begin
            timed = 1'b1;
            if (clk_fall) begin
               ack_ok_d = ~sync_dat;
               tocnt_d  = '0;
               state_d  = StWaitIdle;
            end
         end
         StWaitIdle: begin
            timed = 1'b1;
            if (sync_clk && sync_dat) begin
               done_d  = ack_ok_q;
               error_d = ~ack_ok_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Completion wins over a coincident timeout.
      if (timed && (tocnt_q == TimeoutLast) && (state_d != StIdle)) begin
         state_d  = StIdle;
         dat_oe_d = 1'b0;
         done_d   = 1'b0;
         error_d  = 1'b1;
      end
   end

   assign tx_busy    = (state_q != StIdle);
   assign ps2_clk_oe = (state_q == StInhibit) || (state_q == StReq);
   assign ps2_dat_oe = dat_oe_q;
   assign tx_done    = done_q;
   assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the
// open-collector lines; timing parameters are scaled down.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned Inh  = 60;
   localparam int unsigned Req  = 12;
   localparam int unsigned To   = 500;
   localparam int unsigned Half = 30;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx_busy, tx_done, tx_error;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;

   int n_checks = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int busy_bad = 0;
   logic busy_prev = 1'b0;

   assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
   assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

   ps2_host_tx #(
      .INHIBIT_CYCLES (Inh),
      .REQ_CYCLES     (Req),
      .TIMEOUT_CYCLES (To)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #10 Clk = ~Clk;

   // Pulse monitor: busy must be high the cycle before and low during a pulse.
   always @(negedge Clk) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) both_cnt++;
      if ((tx_done || tx_error) && (tx_busy || !busy_prev)) busy_bad++;
      busy_prev = tx_busy;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic start_tx(input logic [7:0] b);
      @(negedge Clk);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge Clk);
      tx_start = 1'b0;
   endtask

   task automatic measure_request(output int inh, output int req);
      inh = 0;
      req = 0;
      while (ps2_clk_oe && !ps2_dat_oe && inh < 5000) begin
         inh++;
         @(negedge Clk);
      end
      while (ps2_clk_oe && ps2_dat_oe && req < 5000) begin
         req++;
         @(negedge Clk);
      end
   endtask

   // Device samples the line on each rising clock; acks before the 11th fall.
   task automatic run_device(input int n_falls, input logic ack, output logic [9:0] bits);
      bits = '0;
      for (int k = 1; k <= n_falls; k++) begin
         repeat (Half) @(negedge Clk);
         dev_clk = 1'b0;
         repeat (Half) @(negedge Clk);
         dev_clk = 1'b1;
         if (k <= 10) bits[k-1] = ps2_dat_in;
         if (k == 10) dev_dat = ack;
         if (k == 11) dev_dat = 1'b1;
      end
   endtask

   task automatic wait_end(input int d0, input int e0);
      int t;
      t = 0;
      while (done_cnt == d0 && err_cnt == e0 && t < 300) begin
         @(negedge Clk);
         t++;
      end
      check("end_seen", {31'd0, t < 300}, 32'd1);
      repeat (20) @(negedge Clk);
   endtask

   task automatic full_tx(input string tag, input logic [7:0] b, input logic ack,
                          input logic [9:0] exp_bits, input int exp_done, input int exp_err);
      int d0, e0, inh, req;
      logic [9:0] bits;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(b);
      measure_request(inh, req);
      run_device(11, ack, bits);
      wait_end(d0, e0);
      check({tag, "_bits"}, {22'd0, bits}, {22'd0, exp_bits});
      check({tag, "_done"}, done_cnt - d0, exp_done);
      check({tag, "_err"}, err_cnt - e0, exp_err);
   endtask

   initial begin
      int inh, req, d0, e0, t;
      logic [9:0] bits;

      repeat (3) @(negedge Clk);
      check("reset_outs", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);

      // 0xF4 with ack: request timing, frame bits, single done.
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(PS2_CMD_ENABLE);
      measure_request(inh, req);
      check("f4_inhibit", inh, Inh);
      check("f4_req", req, Req);
      run_device(11, 1'b0, bits);
      wait_end(d0, e0);
      check("f4_bits", {22'd0, bits}, 32'h2F4);
      check("f4_done", done_cnt - d0, 1);
      check("f4_err", err_cnt - e0, 0);
      check("f4_busy", {31'd0, tx_busy}, 0);

      full_tx("ff", PS2_CMD_RESET, 1'b0, 10'h3FF, 1, 0);
      full_tx("nak", 8'h00, 1'b1, 10'h300, 0, 1);

      // Device never clocks: timeout counted from clock release.
      d0 = done_cnt;
      start_tx(PS2_CMD_ENABLE);
      measure_request(inh, req);
      t = 0;
      while (!tx_error && t < 2 * To) begin
         @(negedge Clk);
         t++;
      end
      check("to_cycles", t, To);
      check("to_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
      check("to_busy", {31'd0, tx_busy}, 0);
      repeat (5) @(negedge Clk);
      check("to_nodone", done_cnt - d0, 0);

      // Reset after the 4th data fall: asynchronous release, no pulses.
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(PS2_CMD_ENABLE);
      measure_request(inh, req);
      run_device(4, 1'b0, bits);
      check("rst_pre", {30'd0, ps2_dat_oe, tx_busy}, 32'd3);
      @(negedge Clk);
      #3 Reset = 1'b1;
      #1 check("rst_async", {29'd0, ps2_clk_oe, ps2_dat_oe, tx_busy}, 0);
      repeat (4) @(negedge Clk);
      Reset = 1'b0;
      repeat (10) @(negedge Clk);
      check("rst_nopulse", (done_cnt - d0) + (err_cnt - e0), 0);
      full_tx("post_rst", PS2_CMD_ENABLE, 1'b0, 10'h2F4, 1, 0);

      // Second start while busy is ignored.
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(PS2_CMD_ENABLE);
      repeat (3) @(negedge Clk);
      start_tx(8'h12);
      measure_request(inh, req);
      run_device(11, 1'b0, bits);
      wait_end(d0, e0);
      check("busy_bits", {22'd0, bits}, 32'h2F4);
      repeat (2 * Inh) @(negedge Clk);
      check("busy_done", done_cnt - d0, 1);
      check("busy_idle", {30'd0, tx_busy, ps2_clk_oe}, 0);

      check("never_both", both_cnt, 0);
      check("busy_vs_pulse", busy_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
